// File: rtl/alu_main_dec_if.sv
// Control bus between the multicycle main decoder and the datapath:
// the opcode goes in, the mux selects and write enables come out.
interface alu_main_dec_if;
    logic [5:0] op;
    logic       Mem2Reg;
    logic       RegDs;
    logic       IrD;
    logic [1:0] PCSr;
    logic       ALUSrA;
    logic [1:0] ALUSrB;
    logic       IRWr;
    logic       MemWr;
    logic       PCWr;
    logic       Brnch;
    logic       RegWr;
    logic [1:0] ALUop;

    modport master (
        input  op,
        output Mem2Reg, RegDs, IrD, PCSr, ALUSrA, ALUSrB,
               IRWr, MemWr, PCWr, Brnch, RegWr, ALUop
    );

    modport slave (
        output op,
        input  Mem2Reg, RegDs, IrD, PCSr, ALUSrA, ALUSrB,
               IRWr, MemWr, PCWr, Brnch, RegWr, ALUop
    );
endinterface

// File: rtl/alu_main_dec.sv
// Moore main-control FSM of the multicycle MIPS-subset processor.
// Define MAINDEC_STATE_DBG_EN to expose the current state on StateDbg.
module alu_main_dec #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic               CLK,
    input  logic               RESET,
    alu_main_dec_if.master     bus
`ifdef MAINDEC_STATE_DBG_EN
    ,
    output logic [3:0]         StateDbg
`endif
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        unique case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (bus.op == OP_LW || bus.op == OP_SW) state_d = MEMADR;
                else if (bus.op == OP_RTYPE)            state_d = EXECUTE;
                else if (bus.op == OP_BEQ)              state_d = BEQ;
                else if (bus.op == OP_ADDI)             state_d = ADDIEX;
                else if (bus.op == OP_J)                state_d = JUMP;
                else                                    state_d = FETCH;
            end
            MEMADR: begin
                if (bus.op == OP_LW)      state_d = MEMRD;
                else if (bus.op == OP_SW) state_d = MEMWR;
                else                      state_d = FETCH;
            end
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Outputs depend on state_q only; op never reaches them combinationally.
    always_comb begin
        bus.Mem2Reg = 1'b0;
        bus.RegDs   = 1'b0;
        bus.IrD     = 1'b0;
        bus.PCSr    = 2'b00;
        bus.ALUSrA  = 1'b0;
        bus.ALUSrB  = 2'b00;
        bus.IRWr    = 1'b0;
        bus.MemWr   = 1'b0;
        bus.PCWr    = 1'b0;
        bus.Brnch   = 1'b0;
        bus.RegWr   = 1'b0;
        bus.ALUop   = 2'b00;
        case (state_q)
            FETCH: begin
                bus.IRWr   = 1'b1;
                bus.PCWr   = 1'b1;
                bus.ALUSrB = 2'b01;
            end
            DECODE:  bus.ALUSrB = 2'b11;
            MEMADR: begin
                bus.ALUSrA = 1'b1;
                bus.ALUSrB = 2'b10;
            end
            MEMRD:   bus.IrD = 1'b1;
            MEMWB: begin
                bus.RegWr   = 1'b1;
                bus.Mem2Reg = 1'b1;
            end
            MEMWR: begin
                bus.IrD   = 1'b1;
                bus.MemWr = 1'b1;
            end
            EXECUTE: begin
                bus.ALUSrA = 1'b1;
                bus.ALUop  = 2'b10;
            end
            ALUWB: begin
                bus.RegWr = 1'b1;
                bus.RegDs = 1'b1;
            end
            BEQ: begin
                bus.ALUSrA = 1'b1;
                bus.ALUop  = 2'b01;
                bus.PCSr   = 2'b01;
                bus.Brnch  = 1'b1;
            end
            ADDIEX: begin
                bus.ALUSrA = 1'b1;
                bus.ALUSrB = 2'b10;
            end
            ADDIWB:  bus.RegWr = 1'b1;
            JUMP: begin
                bus.PCSr = 2'b10;
                bus.PCWr = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MAINDEC_STATE_DBG_EN
    assign StateDbg = state_q;
`endif

endmodule

// File: tb/tb_alu_main_dec.sv
// Directed-vector bench for the main-control FSM; output vectors are
// packed {Mem2Reg,RegDs,IrD,PCSr,ALUSrA,ALUSrB,IRWr,MemWr,PCWr,Brnch,RegWr,ALUop}.
module tb_alu_main_dec;

    localparam logic [14:0] V_FETCH   = 15'b0_0_0_00_0_01_1_0_1_0_0_00;
    localparam logic [14:0] V_DECODE  = 15'b0_0_0_00_0_11_0_0_0_0_0_00;
    localparam logic [14:0] V_MEMADR  = 15'b0_0_0_00_1_10_0_0_0_0_0_00;
    localparam logic [14:0] V_MEMRD   = 15'b0_0_1_00_0_00_0_0_0_0_0_00;
    localparam logic [14:0] V_MEMWB   = 15'b1_0_0_00_0_00_0_0_0_0_1_00;
    localparam logic [14:0] V_MEMWR   = 15'b0_0_1_00_0_00_0_1_0_0_0_00;
    localparam logic [14:0] V_EXECUTE = 15'b0_0_0_00_1_00_0_0_0_0_0_10;
    localparam logic [14:0] V_ALUWB   = 15'b0_1_0_00_0_00_0_0_0_0_1_00;
    localparam logic [14:0] V_BEQ     = 15'b0_0_0_01_1_00_0_0_0_1_0_01;
    localparam logic [14:0] V_ADDIEX  = 15'b0_0_0_00_1_10_0_0_0_0_0_00;
    localparam logic [14:0] V_ADDIWB  = 15'b0_0_0_00_0_00_0_0_0_0_1_00;
    localparam logic [14:0] V_JUMP    = 15'b0_0_0_10_0_00_0_0_1_0_0_00;

    logic        clk;
    logic        rst_n;
    logic [14:0] outs;
    int          total;
    int          bad;

    alu_main_dec_if bus ();

    alu_main_dec dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.master)
    );

    assign outs = {bus.Mem2Reg, bus.RegDs, bus.IrD, bus.PCSr, bus.ALUSrA, bus.ALUSrB,
                   bus.IRWr, bus.MemWr, bus.PCWr, bus.Brnch, bus.RegWr, bus.ALUop};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.op = 6'h08;
        rst_n  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (outs !== V_FETCH) begin
                bad++;
                $display("FAIL reset edge%0d: got %b want %b", i, outs, V_FETCH);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        logic [14:0] e [4];
        e = '{V_DECODE, V_ADDIEX, V_ADDIWB, V_FETCH};
        bus.op = 6'h08;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL addi cyc%0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_lw();
        logic [14:0] e [5];
        e = '{V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
        bus.op = 6'h23;
        for (int i = 0; i < 5; i++) begin
            tick();
            // op is ignored outside DECODE/MEMADR, so disturbing it in MEMRD must not matter
            if (i == 2) bus.op = 6'h2B;
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL lw cyc%0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [14:0] e [4];
        e = '{V_DECODE, V_MEMADR, V_MEMWR, V_FETCH};
        bus.op = 6'h2B;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL sw cyc%0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [14:0] e [4];
        e = '{V_DECODE, V_EXECUTE, V_ALUWB, V_FETCH};
        bus.op = 6'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL rtype cyc%0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_beq();
        logic [14:0] e [3];
        e = '{V_DECODE, V_BEQ, V_FETCH};
        bus.op = 6'h04;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL beq cyc%0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_jump();
        logic [14:0] e [3];
        e = '{V_DECODE, V_JUMP, V_FETCH};
        bus.op = 6'h02;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL jump cyc%0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_unknown();
        logic [14:0] e [2];
        e = '{V_DECODE, V_FETCH};
        bus.op = 6'h3F;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL unknown cyc%0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] e [4];
        logic        wr_seen;
        e = '{V_DECODE, V_MEMADR, V_MEMRD, V_FETCH};
        wr_seen = 1'b0;
        bus.op  = 6'h23;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rst_n = 1'b0;
            tick();
            wr_seen = wr_seen | bus.MemWr | bus.RegWr;
            total++;
            if (outs !== e[i]) begin
                bad++;
                $display("FAIL reset_mid cyc%0d: got %b want %b", i, outs, e[i]);
            end
        end
        rst_n = 1'b1;
        total++;
        if (wr_seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_nowrite: got %b want 0", wr_seen);
        end
        bus.op = 6'h02;
        tick();
        total++;
        if (outs !== V_DECODE) begin
            bad++;
            $display("FAIL after_reset_mid: got %b want %b", outs, V_DECODE);
        end
        tick();
        tick();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        bus.op = 6'h08;
        test_reset();
        test_addi();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_jump();
        test_unknown();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
